// File: rtl/neuron_wb_master.sv
// Single-outstanding Wishbone classic initiator bridging a valid/ready command port to a bus cycle.
// Optional bus timeout is built when NEURON_WB_MASTER_TIMEOUT_EN is defined.
module neuron_wb_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t state;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 1..65535");
    end

`ifdef NEURON_WB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
`ifdef NEURON_WB_MASTER_TIMEOUT_EN
            rsp_err   <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_we ? cmd_dat : 32'h0;
                        wbm_sel_o <= cmd_sel;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
`ifdef NEURON_WB_MASTER_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                        state     <= BUS;
                    end
                end
                BUS: begin
                    // An ack on the same edge as the timeout wins.
                    if (wbm_ack_i) begin
                        rsp_dat   <= wbm_we_o ? 32'h0 : wbm_dat_i;
`ifdef NEURON_WB_MASTER_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        rsp_valid <= 1'b1;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        state     <= RESP;
                    end
`ifdef NEURON_WB_MASTER_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        rsp_dat   <= 32'h0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        state     <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_wb_master.sv
// Scoreboard bench for neuron_wb_master: randomized commands, behavioural responder and response checker.
module tb_neuron_wb_master;

    localparam int TO = 4;
`ifdef NEURON_WB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        busy;

    neuron_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          len;
        int          acc;
        bit          chk_rt;
        int          delay;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_fail = 0;
    int cyc_cnt = 0;

    // Responder's view of the command currently on the bus.
    logic        cur_we = 1'b0;
    logic [31:0] cur_adr = '0, cur_dat = '0, cur_rdata = '0;
    logic [3:0]  cur_sel = '0;
    int          cur_delay = 1;

    int  hold_left = 0;
    bit  ready_all = 1'b0;
    bit  force_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Wishbone responder and response monitor.
    int   bus_cnt = 0;
    int   last_len = 0;
    bit   prev_wait = 1'b0;
    logic [31:0] prev_dat = '0;
    logic        prev_err = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            bus_cnt   = 0;
            prev_wait = 1'b0;
            wbm_ack_i = 1'b0;
            rsp_ready = 1'b0;
        end else begin
            if (wbm_cyc_o) begin
                bus_cnt++;
                check("bus_stb", wbm_stb_o, 1'b1);
                check("bus_we", wbm_we_o, cur_we);
                check("bus_adr", wbm_adr_o, cur_adr);
                check("bus_dat", wbm_dat_o, cur_we ? cur_dat : 32'h0);
                check("bus_sel", wbm_sel_o, cur_sel);
                check("bus_cmd_ready", cmd_ready, 1'b0);
                check("bus_busy", busy, 1'b1);
                if (bus_cnt == cur_delay) begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = cur_rdata;
                end else begin
                    wbm_ack_i = 1'b0;
                    wbm_dat_i = $urandom;
                end
            end else begin
                if (bus_cnt != 0) last_len = bus_cnt;
                bus_cnt   = 0;
                wbm_ack_i = force_ack ? 1'b1 : ($urandom_range(0, 3) == 0);
                wbm_dat_i = $urandom;
            end

            if (prev_wait) begin
                check("rsp_hold_valid", rsp_valid, 1'b1);
                check("rsp_hold_dat", rsp_dat, prev_dat);
                check("rsp_hold_err", rsp_err, prev_err);
            end
            if (rsp_valid) begin
                check("rsp_cmd_ready", cmd_ready, 1'b0);
                check("rsp_busy", busy, 1'b1);
                if (hold_left > 0) begin
                    rsp_ready = 1'b0;
                    hold_left--;
                end else if (ready_all) begin
                    rsp_ready = 1'b1;
                end else begin
                    rsp_ready = ($urandom_range(0, 2) != 0);
                end
                if (rsp_ready) begin
                    prev_wait = 1'b0;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: got response dat=%h err=%b, want none", rsp_dat, rsp_err);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_dat", rsp_dat, e.dat);
                        check("rsp_err", rsp_err, e.err);
                        check("bus_len", last_len, e.len);
                        if (e.chk_rt) check("round_trip", cyc_cnt + 2 - e.acc, e.delay + 2);
                    end
                end else begin
                    prev_wait = 1'b1;
                    prev_dat  = rsp_dat;
                    prev_err  = rsp_err;
                end
            end else begin
                prev_wait = 1'b0;
                rsp_ready = ($urandom_range(0, 1) == 1);
            end
        end
    end

    // Waits for an idle block (driving junk commands meanwhile), presents one command, records the expectation.
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int delay, input logic [31:0] rdata,
                         input bit chk_rt, output int acc);
        exp_t e;
        int guard = 0;
        acc = 0;
        while (cmd_ready !== 1'b1) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_we    = ($urandom_range(0, 1) == 1);
            cmd_adr   = $urandom;
            cmd_dat   = $urandom;
            cmd_sel   = 4'($urandom);
            @(negedge clk);
            guard++;
            if (guard > 300) begin
                n_cmp++;
                n_fail++;
                $display("FAIL issue_timeout: cmd_ready=%b after %0d cycles, want 1", cmd_ready, guard);
                cmd_valid = 1'b0;
                return;
            end
        end
        cur_we    = we;
        cur_adr   = adr;
        cur_dat   = dat;
        cur_sel   = sel;
        cur_delay = delay;
        cur_rdata = rdata;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        @(posedge clk);
        #1;
        acc = cyc_cnt;
        check("accept_cyc", wbm_cyc_o, 1'b1);
        check("accept_ready", cmd_ready, 1'b0);
        e.err    = TO_EN && (delay > TO);
        e.dat    = (we || e.err) ? 32'h0 : rdata;
        e.len    = e.err ? TO : delay;
        e.acc    = acc;
        e.chk_rt = chk_rt;
        e.delay  = delay;
        sb.push_back(e);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 || cmd_ready !== 1'b1) begin
            @(negedge clk);
            g++;
            if (g > 300) begin
                n_cmp++;
                n_fail++;
                $display("FAIL drain_timeout: pending=%0d, want 0", sb.size());
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, rel;
        logic we;
        logic [31:0] adr, dat, rdata;
        logic [3:0] sel;
        int delay;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_cyc", wbm_cyc_o, 1'b0);
        check("rst_stb", wbm_stb_o, 1'b0);
        check("rst_we", wbm_we_o, 1'b0);
        check("rst_adr", wbm_adr_o, 32'h0);
        check("rst_dat", wbm_dat_o, 32'h0);
        check("rst_sel", wbm_sel_o, 4'h0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_dat", rsp_dat, 32'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        // Directed write and 3-cycle read.
        issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2, 32'h0, 1'b0, acc);
        drain();
        ready_all = 1'b1;
        issue(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1, 32'h0000_00A5, 1'b1, acc);
        drain();
        ready_all = 1'b0;

        // Response held off while the next command waits, with acks spraying outside BUS.
        force_ack = 1'b1;
        hold_left = 5;
        issue(1'b0, 32'h3000_0014, 32'h0, 4'h3, 3, 32'h1357_9BDF, 1'b0, acc);
        issue(1'b1, 32'h3000_0018, 32'h0BAD_F00D, 4'hC, 1, 32'h0, 1'b0, acc);
        drain();
        repeat (4) begin
            @(posedge clk);
            #1;
            check("idle_ack_cyc", wbm_cyc_o, 1'b0);
            check("idle_ack_ready", cmd_ready, 1'b1);
            check("idle_ack_rsp", rsp_valid, 1'b0);
        end
        force_ack = 1'b0;

        // No ack within the window, then ack on the last allowed cycle.
        issue(1'b0, 32'h3000_0020, 32'h0, 4'hF, 10, 32'hFFFF_0001, 1'b0, acc);
        issue(1'b0, 32'h3000_0024, 32'h0, 4'hF, TO, 32'h8000_0042, 1'b0, acc);
        drain();

        // Reset in the middle of a bus cycle.
        issue(1'b1, 32'h1234_5678, 32'hCAFE_F00D, 4'h3, 30, 32'h0, 1'b0, acc);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_cyc", wbm_cyc_o, 1'b0);
        check("midrst_stb", wbm_stb_o, 1'b0);
        check("midrst_ready", cmd_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_rsp", rsp_valid, 1'b0);
        check("midrst_adr", wbm_adr_o, 32'h0);
        if (sb.size() > 0) sb.delete(sb.size() - 1);
        repeat (2) @(negedge clk);
        check("midrst_rsp_late", rsp_valid, 1'b0);
        rst_n = 1'b1;
        rel = cyc_cnt;
        issue(1'b0, 32'h3000_0030, 32'h0, 4'hF, 2, 32'h5A5A_0001, 1'b0, acc);
        check("first_edge_accept", acc, rel + 1);
        drain();

        for (int i = 0; i < 40; i++) begin
            we    = ($urandom_range(0, 1) == 1);
            adr   = $urandom;
            dat   = $urandom;
            sel   = 4'($urandom);
            delay = $urandom_range(1, 7);
            rdata = $urandom;
            if ($urandom_range(0, 4) == 0) hold_left = $urandom_range(1, 4);
            issue(we, adr, dat, sel, delay, rdata, 1'b0, acc);
            if ($urandom_range(0, 3) == 0) begin
                drain();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
